// File: rtl/iir_serial_sched.sv
// Serial direct-form IIR section: one registered multiplier shared by all taps.
// Ports: clk/rst(async low)/clr; in_valid,in_ready,x_in; cfg_*; y_out,out_valid,sat_flag,busy.
module iir_serial_sched #(
  parameter int DW       = 12,
  parameter int CW       = 12,
  parameter int NZ       = 8,
  parameter int NP       = 7,
  parameter int MULT_LAT = 1,
  parameter int AW       = 26,
  parameter int SHIFT    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_in,
  input  logic                 cfg_we,
  input  logic [4:0]           cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  output logic                 cfg_err,
  output logic signed [DW-1:0] y_out,
  output logic                 out_valid,
  output logic                 sat_flag,
  output logic                 busy
);

  localparam int NT  = NZ + NP;
  localparam int KW  = $clog2(NT + 1);
  localparam int PW  = DW + CW;
  localparam int DCW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  localparam logic signed [AW-1:0] YMAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] YMIN = -YMAX - AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;

  logic signed [DW-1:0] x_q [NZ];
  logic signed [DW-1:0] y_q [NP];
  logic signed [CW-1:0] coef_q [NT];

  logic signed [PW-1:0] pp_q [MULT_LAT];
  logic [MULT_LAT-1:0]  pv_q;
  logic [MULT_LAT-1:0]  psub_q;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] y_out_q;
  logic                 out_valid_q;
  logic                 sat_q;
  logic                 cfg_err_q;

  logic                 accept;
  logic                 done;
  logic                 issue;
  logic                 cfg_ok;
  logic signed [CW-1:0] op_c;
  logic signed [DW-1:0] op_d;
  logic signed [PW-1:0] prod_c;
  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] ysh;
  logic signed [DW-1:0] y_sat;
  logic                 sat_c;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign issue     = (state_q == S_MAC);
  assign y_out     = y_out_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;
  assign cfg_err   = cfg_err_q;

  assign cfg_ok = cfg_we && (state_q == S_IDLE)
               && (cfg_addr < 5'(NT));

  // FSM next state
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      k_d     = '0;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            accept  = 1'b1;
            state_d = S_MAC;
            k_d     = '0;
          end
        end
        S_MAC: begin
          if (k_q == KW'(NT - 1)) begin
            state_d = S_DRAIN;
            k_d     = '0;
            dcnt_d  = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == DCW'(MULT_LAT - 1)) begin
            state_d = S_DONE;
          end else begin
            dcnt_d = dcnt_q + DCW'(1);
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Operand select: taps 0..NZ-1 use x line, the rest use y line
  always_comb begin
    op_c = '0;
    op_d = '0;
    for (int i = 0; i < NT; i++) begin
      if (k_q == KW'(i)) op_c = coef_q[i];
    end
    for (int i = 0; i < NZ; i++) begin
      if (k_q == KW'(i)) op_d = x_q[i];
    end
    for (int i = 0; i < NP; i++) begin
      if (k_q == KW'(NZ + i)) op_d = y_q[i];
    end
  end

  assign prod_c = PW'(op_c) * PW'(op_d);

  // Multiplier pipeline; valid and sign travel with each product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q   <= '0;
      psub_q <= '0;
      for (int i = 0; i < MULT_LAT; i++) pp_q[i] <= '0;
    end else if (clr) begin
      pv_q   <= '0;
      psub_q <= '0;
    end else begin
      pv_q[0]   <= issue;
      psub_q[0] <= (k_q >= KW'(NZ));
      pp_q[0]   <= prod_c;
      for (int i = 1; i < MULT_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        psub_q[i] <= psub_q[i-1];
        pp_q[i]   <= pp_q[i-1];
      end
    end
  end

  assign ext = {{(AW - PW){pp_q[MULT_LAT-1][PW-1]}},
                pp_q[MULT_LAT-1]};

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (pv_q[MULT_LAT-1]) begin
      acc_d = psub_q[MULT_LAT-1] ? (acc_q - ext)
                                 : (acc_q + ext);
    end
  end

  // Scale and clip
  always_comb begin
    ysh   = acc_q >>> SHIFT;
    sat_c = 1'b0;
    y_sat = ysh[DW-1:0];
    if (ysh > YMAX) begin
      sat_c = 1'b1;
      y_sat = {1'b0, {(DW - 1){1'b1}}};
    end else if (ysh < YMIN) begin
      sat_c = 1'b1;
      y_sat = {1'b1, {(DW - 1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Delay lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NZ; i++) x_q[i] <= '0;
      for (int i = 0; i < NP; i++) y_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NZ; i++) x_q[i] <= '0;
      for (int i = 0; i < NP; i++) y_q[i] <= '0;
    end else begin
      if (accept) begin
        x_q[0] <= x_in;
        for (int i = 1; i < NZ; i++) x_q[i] <= x_q[i-1];
      end
      if (done) begin
        y_q[0] <= y_sat;
        for (int i = 1; i < NP; i++) y_q[i] <= y_q[i-1];
      end
    end
  end

  // Coefficient bank survives clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NT; i++) coef_q[i] <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        for (int i = 0; i < NT; i++) begin
          if (cfg_addr == 5'(i)) coef_q[i] <= cfg_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_out_q     <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= done;
      sat_q       <= done && sat_c;
      if (done) y_out_q <= y_sat;
    end
  end

endmodule

// File: tb/tb_iir_serial_sched.sv
// Directed bench for iir_serial_sched: latency, impulse response,
// saturation, cfg rejection, clr and async reset mid-computation.
module tb_iir_serial_sched;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [11:0] x_in = '0;
  logic              cfg_we = 1'b0;
  logic [4:0]        cfg_addr = '0;
  logic signed [11:0] cfg_data = '0;
  logic              cfg_err;
  logic signed [11:0] y_out;
  logic              out_valid;
  logic              sat_flag;
  logic              busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;

  iir_serial_sched dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .y_out    (y_out),
    .out_valid(out_valid),
    .sat_flag (sat_flag),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic accept(input logic signed [11:0] x);
    @(negedge clk);
    check("rdy", 32'(in_ready), 1);
    in_valid = 1'b1;
    x_in = x;
    @(posedge clk);
    #1;
    t0 = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag,
                          output logic signed [11:0] y,
                          output logic s);
    int lat;
    lat = 0;
    y = '0;
    s = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = cyc - t0;
        y = y_out;
        s = sat_flag;
        break;
      end
    end
    check({tag, "_lat"}, lat, 17);
  endtask

  task automatic run(input logic signed [11:0] x,
                     input int ey, input logic es,
                     input string tag);
    logic signed [11:0] y;
    logic s;
    accept(x);
    wait_out(tag, y, s);
    check(tag, y, ey);
    check({tag, "_sat"}, 32'(s), 32'(es));
  endtask

  task automatic cfg(input logic [4:0] a,
                     input logic signed [11:0] d,
                     output logic err);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    err = cfg_err;
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check({tag, "_rdy"}, 32'(in_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic no_out(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  task automatic impulse(input string tag);
    int ey [8];
    ey = '{100, 50, 25, 12, 6, 3, 1, 0};
    for (int i = 0; i < 8; i++) begin
      run((i == 0) ? 12'sd100 : 12'sd0, ey[i], 1'b0,
          $sformatf("%s_%0d", tag, i));
    end
  endtask

  initial begin
    logic e;
    logic signed [11:0] y;
    logic s;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_y", y_out, 0);
    check("rst_ov", 32'(out_valid), 0);
    check("rst_sat", 32'(sat_flag), 0);
    check("rst_err", 32'(cfg_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdy", 32'(in_ready), 1);

    // zero coefficients after reset
    run(12'sd100, 0, 1'b0, "t1_zero");

    // unity gain
    cfg(5'd0, 12'sd512, e);
    check("t2_cfg_ok", 32'(e), 0);
    run(12'sd100, 100, 1'b0, "t2_pos");
    run(-12'sd2048, -2048, 1'b0, "t2_neg");

    // dropped writes
    cfg(5'd15, 12'sd77, e);
    check("t5_addr_err", 32'(e), 1);
    accept(12'sd100);
    repeat (3) @(posedge clk);
    check("t5_busy", 32'(busy), 1);
    check("t5_nrdy", 32'(in_ready), 0);
    cfg(5'd0, 12'sd100, e);
    check("t5_mac_err", 32'(e), 1);
    wait_out("t5_res", y, s);
    check("t5_res", y, 100);

    // write and accept on the same edge: new b0 applies
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 5'd0;
    cfg_data = 12'sd256;
    in_valid = 1'b1;
    x_in = 12'sd100;
    @(posedge clk);
    #1;
    t0 = cyc;
    cfg_we = 1'b0;
    in_valid = 1'b0;
    check("same_edge_err", 32'(cfg_err), 0);
    wait_out("same_edge", y, s);
    check("same_edge", y, 50);
    cfg(5'd0, 12'sd512, e);

    // one pole: y = x + y/2
    cfg(5'd8, -12'sd256, e);
    check("t3_a1_ok", 32'(e), 0);
    do_clr("t3_clr");
    impulse("t3");

    // saturation
    cfg(5'd8, 12'sd0, e);
    cfg(5'd1, 12'sd2047, e);
    cfg(5'd0, 12'sd2047, e);
    do_clr("t4_clr");
    run(12'sd2047, 2047, 1'b1, "t4_p0");
    run(12'sd2047, 2047, 1'b1, "t4_p1");
    run(-12'sd2048, -4, 1'b0, "t4_n0");
    run(-12'sd2048, -2048, 1'b1, "t4_n1");

    // clr mid-MAC
    cfg(5'd1, 12'sd0, e);
    cfg(5'd0, 12'sd512, e);
    cfg(5'd8, -12'sd256, e);
    accept(12'sd100);
    repeat (5) @(posedge clk);
    do_clr("t6_clr");
    check("t6_clr_hold", y_out, -2048);
    no_out("t6_clr_noout", 25);
    impulse("t6c");

    // async reset mid-MAC
    accept(12'sd100);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_rdy", 32'(in_ready), 1);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_y", y_out, 0);
    @(negedge clk);
    rst = 1'b1;
    no_out("t6_rst_noout", 25);
    run(12'sd100, 0, 1'b0, "t6_rst_coef");
    cfg(5'd0, 12'sd512, e);
    cfg(5'd8, -12'sd256, e);
    do_clr("t6r_clr");
    impulse("t6r");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
